// File: rtl/uart_link_ctrl.sv
// Round-robin TX arbiter and one-byte RX holding register in front of a single uart.
// Optional busy-ack timeout: define UART_LINK_TIMEOUT_EN.
module uart_link_ctrl #(
  parameter int NREQ        = 4,
  parameter int ACK_TIMEOUT = 4096
) (
  input  logic              clk_100,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic              uart_send,
  output logic [7:0]        uart_data_in,
  input  logic              uart_busy,
  input  logic              uart_ready,
  input  logic [7:0]        uart_data_out,
  output logic              uart_clr,
  output logic              rx_valid,
  output logic [7:0]        rx_data,
  input  logic              rx_ack,
  output logic              rx_overrun,
  output logic              tx_err
);

  localparam int IDXW = $clog2(NREQ);

  localparam logic [1:0] T_IDLE  = 2'd0;
  localparam logic [1:0] T_SEND  = 2'd1;
  localparam logic [1:0] T_DRAIN = 2'd2;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_CLR   = 2'd1;
  localparam logic [1:0] R_WAIT  = 2'd2;

  logic            busy_meta_r;
  logic            busy_s;
  logic            ready_meta_r;
  logic            ready_s;
  logic [1:0]      tx_state_r;
  logic [1:0]      rx_state_r;
  logic [IDXW-1:0] last_r;
  logic [IDXW-1:0] pick_idx_s;
  logic            pick_found_s;
  logic [NREQ-1:0] gnt_r;
  logic            uart_send_r;
  logic [7:0]      uart_data_in_r;
  logic            tx_err_r;
  logic            uart_clr_r;
  logic            rx_valid_r;
  logic [7:0]      rx_data_r;
  logic            rx_overrun_r;

`ifdef UART_LINK_TIMEOUT_EN
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt_r;
`endif

  // First requesting index after l, wrapping; returns {found, index}.
  function automatic logic [IDXW:0] rr_pick(input logic [NREQ-1:0] r, input logic [IDXW-1:0] l);
    logic [IDXW:0] res;
    int            idx;
    res = {(IDXW+1){1'b0}};
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(l) + k) % NREQ;
      if (r[idx]) begin
        res = {1'b1, idx[IDXW-1:0]};
      end
    end
    return res;
  endfunction

  // Round-robin selection for the next grant.
  always_comb begin
    {pick_found_s, pick_idx_s} = rr_pick(req, last_r);
  end

  // Two-flop synchronizers for the uart status lines.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      busy_meta_r  <= 1'b0;
      busy_s       <= 1'b0;
      ready_meta_r <= 1'b0;
      ready_s      <= 1'b0;
    end else begin
      busy_meta_r  <= uart_busy;
      busy_s       <= busy_meta_r;
      ready_meta_r <= uart_ready;
      ready_s      <= ready_meta_r;
    end
  end

  // TX sequencing: grant, hold send until busy seen, wait for busy to clear.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_r     <= T_IDLE;
      last_r         <= IDXW'(NREQ - 1);
      gnt_r          <= {NREQ{1'b0}};
      uart_send_r    <= 1'b0;
      uart_data_in_r <= 8'h00;
      tx_err_r       <= 1'b0;
`ifdef UART_LINK_TIMEOUT_EN
      tmo_cnt_r      <= {CNT_W{1'b0}};
`endif
    end else begin
      gnt_r    <= {NREQ{1'b0}};
      tx_err_r <= 1'b0;
      case (tx_state_r)
        T_IDLE: begin
          if (!busy_s && pick_found_s) begin
            gnt_r          <= NREQ'(1'b1) << pick_idx_s;
            uart_data_in_r <= req_data[8*pick_idx_s +: 8];
            last_r         <= pick_idx_s;
            uart_send_r    <= 1'b1;
            tx_state_r     <= T_SEND;
`ifdef UART_LINK_TIMEOUT_EN
            tmo_cnt_r      <= {CNT_W{1'b0}};
`endif
          end
        end
        T_SEND: begin
          if (busy_s) begin
            uart_send_r <= 1'b0;
            tx_state_r  <= T_DRAIN;
          end
`ifdef UART_LINK_TIMEOUT_EN
          // Byte is abandoned; last_r keeps its advance so the next requester goes first.
          else if (tmo_cnt_r == CNT_W'(ACK_TIMEOUT - 1)) begin
            uart_send_r <= 1'b0;
            tx_err_r    <= 1'b1;
            tx_state_r  <= T_IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
          end
`endif
        end
        T_DRAIN: begin
          if (!busy_s) begin
            tx_state_r <= T_IDLE;
          end
        end
        default: begin
          uart_send_r <= 1'b0;
          tx_state_r  <= T_IDLE;
        end
      endcase
    end
  end

  // RX capture, one-cycle clr, and wait for ready to fall before re-arming.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_r   <= R_IDLE;
      uart_clr_r   <= 1'b0;
      rx_valid_r   <= 1'b0;
      rx_data_r    <= 8'h00;
      rx_overrun_r <= 1'b0;
    end else begin
      rx_overrun_r <= 1'b0;
      if (rx_valid_r && rx_ack) begin
        rx_valid_r <= 1'b0;
      end
      case (rx_state_r)
        R_IDLE: begin
          if (ready_s) begin
            rx_data_r    <= uart_data_out;
            rx_valid_r   <= 1'b1;
            rx_overrun_r <= rx_valid_r & ~rx_ack;
            rx_state_r   <= R_CLR;
          end
        end
        R_CLR: begin
          uart_clr_r <= 1'b1;
          rx_state_r <= R_WAIT;
        end
        R_WAIT: begin
          uart_clr_r <= 1'b0;
          if (!ready_s) begin
            rx_state_r <= R_IDLE;
          end
        end
        default: begin
          uart_clr_r <= 1'b0;
          rx_state_r <= R_IDLE;
        end
      endcase
    end
  end

  assign gnt          = gnt_r;
  assign uart_send    = uart_send_r;
  assign uart_data_in = uart_data_in_r;
  assign tx_err       = tx_err_r;
  assign uart_clr     = uart_clr_r;
  assign rx_valid     = rx_valid_r;
  assign rx_data      = rx_data_r;
  assign rx_overrun   = rx_overrun_r;

endmodule
